// File: rtl/dm_arbiter.sv
// dm_arbiter: arbitrates two masters onto one single-port data memory, one access per 3 cycles.
// Define DM_ARB_RR_EN for round-robin tie-breaking; otherwise m0 has fixed priority.

module dm_arbiter #(
  parameter int DM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [2:0]  m0_load,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [2:0]  m1_load,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] rdata,
  output logic        dm_we,
  output logic [2:0]  dm_load,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  // Comparing the full byte address against 4*DM_WORDS is the same test as addr[31:2] >= DM_WORDS.
  localparam logic [33:0] BYTE_LIMIT = 34'(DM_WORDS) << 2;

  state_t      state, state_next;
  logic        grant;
  logic        grant_id;
  logic [31:0] sel_addr;
  logic        sel_oor;

  logic        lat_id;
  logic        lat_we;
  logic        lat_err;
  logic [2:0]  lat_load;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

`ifdef DM_ARB_RR_EN
  logic last_id;

  always_comb begin
    grant_id = m1_req;
    if (m0_req && m1_req) grant_id = ~last_id;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     last_id <= 1'b1;
    else if (grant) last_id <= grant_id;
  end
`else
  always_comb begin
    grant_id = ~m0_req;
  end
`endif

  assign sel_addr = grant_id ? m1_addr : m0_addr;
  assign sel_oor  = ({2'b00, sel_addr} >= BYTE_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_load  <= 3'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else if (grant) begin
      lat_id    <= grant_id;
      lat_we    <= grant_id ? m1_we    : m0_we;
      lat_err   <= sel_oor;
      lat_load  <= grant_id ? m1_load  : m0_load;
      lat_addr  <= sel_addr;
      lat_wdata <= grant_id ? m1_wdata : m0_wdata;
    end
  end

  // Only in-range loads update rdata; stores and errors leave the previous result visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     rdata <= 32'd0;
    else if (state == ACCESS && !lat_we && !lat_err) rdata <= dm_rdata;
  end

  assign dm_we    = (state == ACCESS) && lat_we && !lat_err;
  assign dm_load  = lat_load;
  assign dm_addr  = lat_addr;
  assign dm_wdata = lat_wdata;

  assign busy   = (state != IDLE);
  assign m0_ack = (state == RESP) && !lat_id;
  assign m1_ack = (state == RESP) && lat_id;
  assign m0_err = m0_ack && lat_err;
  assign m1_err = m1_ack && lat_err;

endmodule
